// File: rtl/assoc_layer_learner.sv
// Associative layer learning engine.
// Each start handshake presents the winning class; the directed edge
// prev->cur is strengthened (saturating), and the strongest response per key
// class is tracked for registered recall.
// Optional feature macro: ASSOC_DECAY_EN -- after each edge update, sweep the
// row w[prev][*] and weaken every edge except the one just reinforced.
module assoc_layer_learner #(
  parameter int NUM_CLASS = 16,
  parameter int CLASS_W   = $clog2(NUM_CLASS),
  parameter int W_WIDTH   = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_assoc_learning_start,
  input  logic [CLASS_W-1:0] i_class_id,
  input  logic               i_chain_clear,
  output logic               o_assoc_learning_done,
  output logic               o_busy,
  output logic               o_sat_flag,
  output logic               o_err_flag,
  input  logic [CLASS_W-1:0] i_recall_class,
  output logic [CLASS_W-1:0] o_recall_resp,
  output logic [W_WIDTH-1:0] o_recall_weight,
  output logic               o_recall_valid
);

  localparam logic [W_WIDTH-1:0] W_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_READ, ST_UPDATE,
`ifdef ASSOC_DECAY_EN
    ST_DECAY,
`endif
    ST_DONE, ST_WAIT_LOW
  } state_t;

  state_t r_state, w_state_nxt;

  logic [W_WIDTH-1:0] r_w         [NUM_CLASS][NUM_CLASS];
  logic [CLASS_W-1:0] r_best_resp [NUM_CLASS];
  logic [W_WIDTH-1:0] r_best_w    [NUM_CLASS];
  logic [CLASS_W-1:0] r_prev, r_cur;
  logic               r_prev_valid, r_pend_clear;
  logic               r_sat_flag, r_err_flag;
  logic [W_WIDTH-1:0] r_rd_data;
  logic [CLASS_W-1:0] r_recall_resp;
  logic [W_WIDTH-1:0] r_recall_weight;
  logic               r_recall_valid;

  logic               w_cur_bad;
  logic [W_WIDTH-1:0] w_new_w;
  logic [W_WIDTH-1:0] w_best_w_eff;
  logic               w_take;

  function automatic logic [W_WIDTH-1:0] sat_inc(input logic [W_WIDTH-1:0] a);
    return (a == W_MAX) ? W_MAX : a + 1'b1;
  endfunction

`ifdef ASSOC_DECAY_EN
  localparam logic [CLASS_W-1:0] J_LAST = CLASS_W'(NUM_CLASS - 1);
  logic [CLASS_W-1:0] r_j;

  function automatic logic [W_WIDTH-1:0] floor_dec(input logic [W_WIDTH-1:0] a);
    return (a == '0) ? '0 : a - 1'b1;
  endfunction

  // Incumbent loses one unit before the compare unless it is the edge being reinforced.
  assign w_best_w_eff = (r_best_resp[r_prev] != r_cur) ? floor_dec(r_best_w[r_prev])
                                                       : r_best_w[r_prev];
`else
  assign w_best_w_eff = r_best_w[r_prev];
`endif

  assign w_cur_bad = (int'(r_cur) >= NUM_CLASS);
  assign w_new_w   = sat_inc(r_rd_data);
  // Strict greater-than: ties keep the incumbent response.
  assign w_take    = (r_best_resp[r_prev] == r_cur) || (w_new_w > w_best_w_eff);

  assign o_sat_flag      = r_sat_flag;
  assign o_err_flag      = r_err_flag;
  assign o_recall_resp   = r_recall_resp;
  assign o_recall_weight = r_recall_weight;
  assign o_recall_valid  = r_recall_valid;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode plus done/busy outputs.
  always_comb begin
    w_state_nxt           = r_state;
    o_assoc_learning_done = 1'b0;
    o_busy                = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:     if (i_assoc_learning_start) w_state_nxt = ST_CHECK;
      ST_CHECK:    w_state_nxt = (w_cur_bad || !r_prev_valid) ? ST_DONE : ST_READ;
      ST_READ:     w_state_nxt = ST_UPDATE;
`ifdef ASSOC_DECAY_EN
      ST_UPDATE:   w_state_nxt = ST_DECAY;
      ST_DECAY:    if (r_j == J_LAST) w_state_nxt = ST_DONE;
`else
      ST_UPDATE:   w_state_nxt = ST_DONE;
`endif
      ST_DONE: begin
        o_assoc_learning_done = 1'b1;
        w_state_nxt           = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: if (!i_assoc_learning_start) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered weight read of the edge prev->cur, issued while in CHECK.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_CHECK) r_rd_data <= r_w[r_prev][r_cur];
  end

  // Weight/best arrays, chain tracking, sticky flags and recall registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_w             <= '{default: '0};
      r_best_resp     <= '{default: '0};
      r_best_w        <= '{default: '0};
      r_prev          <= '0;
      r_cur           <= '0;
      r_prev_valid    <= 1'b0;
      r_pend_clear    <= 1'b0;
      r_sat_flag      <= 1'b0;
      r_err_flag      <= 1'b0;
      r_recall_resp   <= '0;
      r_recall_weight <= '0;
      r_recall_valid  <= 1'b0;
`ifdef ASSOC_DECAY_EN
      r_j             <= '0;
`endif
    end else begin
      r_recall_resp   <= r_best_resp[i_recall_class];
      r_recall_weight <= r_best_w[i_recall_class];
      r_recall_valid  <= (r_best_w[i_recall_class] != '0);
      case (r_state)
        ST_IDLE: begin
          // A clear arriving with start is applied first: the new class starts a chain.
          if (i_chain_clear || r_pend_clear) r_prev_valid <= 1'b0;
          r_pend_clear <= 1'b0;
          if (i_assoc_learning_start) r_cur <= i_class_id;
        end
        ST_CHECK: if (w_cur_bad) r_err_flag <= 1'b1;
        ST_UPDATE: begin
          r_w[r_prev][r_cur] <= w_new_w;
          if (w_new_w == W_MAX) r_sat_flag <= 1'b1;
          if (w_take) begin
            r_best_resp[r_prev] <= r_cur;
            r_best_w[r_prev]    <= w_new_w;
          end else begin
            r_best_w[r_prev]    <= w_best_w_eff;
          end
`ifdef ASSOC_DECAY_EN
          r_j <= '0;
`endif
        end
`ifdef ASSOC_DECAY_EN
        ST_DECAY: begin
          if (r_j != r_cur) r_w[r_prev][r_j] <= floor_dec(r_w[r_prev][r_j]);
          r_j <= r_j + 1'b1;
        end
`endif
        ST_DONE: begin
          if (!w_cur_bad) begin
            r_prev       <= r_cur;
            r_prev_valid <= 1'b1;
          end
          // A clear seen while busy wins over the chain update above.
          if (r_pend_clear || i_chain_clear) r_prev_valid <= 1'b0;
          r_pend_clear <= 1'b0;
        end
        default: ;
      endcase
      if (r_state != ST_IDLE && r_state != ST_DONE && i_chain_clear) r_pend_clear <= 1'b1;
    end
  end

endmodule

// File: tb/tb_assoc_layer_learner.sv
// Self-checking bench for assoc_layer_learner: done timing scoreboard plus
// a reference model of weights/best responses checked through recall.
`timescale 1ns/1ps
module tb_assoc_layer_learner;
  localparam int NC = 16;
  localparam int CW = 4;
  localparam int WW = 8;
`ifdef ASSOC_DECAY_EN
  localparam int DECAY_CYC = NC;
  localparam int MID_WAIT  = 8;
`else
  localparam int DECAY_CYC = 0;
  localparam int MID_WAIT  = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] class_id = '0;
  logic          chain_clear = 1'b0;
  logic          done, busy, sat, err;
  logic [CW-1:0] recall_class = '0;
  logic [CW-1:0] recall_resp;
  logic [WW-1:0] recall_weight;
  logic          recall_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];

  int w_m[NC][NC];
  int br_m[NC];
  int bw_m[NC];
  int prev_m;
  bit pv_m;
  bit sat_m;

  assoc_layer_learner #(.NUM_CLASS(NC), .CLASS_W(CW), .W_WIDTH(WW)) dut (
    .i_clk(clk), .i_reset(reset), .i_assoc_learning_start(start),
    .i_class_id(class_id), .i_chain_clear(chain_clear),
    .o_assoc_learning_done(done), .o_busy(busy), .o_sat_flag(sat), .o_err_flag(err),
    .i_recall_class(recall_class), .o_recall_resp(recall_resp),
    .o_recall_weight(recall_weight), .o_recall_valid(recall_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the next expected done cycle.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) check_eq("unexpected_done", 1, 0);
      else                   check_eq("done_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      br_m[k] = 0;
      bw_m[k] = 0;
      for (int j = 0; j < NC; j++) w_m[k][j] = 0;
    end
    prev_m = 0; pv_m = 0; sat_m = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; chain_clear = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One learning handshake; clr asserts chain_clear with start, clr_busy pulses it
  // one cycle later while busy, hold keeps start high after done.
  task automatic learn(input int cls, input bit clr, input bit clr_busy, input int hold);
    int n, lat, nw, bw, p;
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) check_eq("idle_timeout", 1, 0);
    if (clr) pv_m = 0;
    if (!pv_m) lat = 2;
    else begin
      lat = 4 + DECAY_CYC;
      p  = prev_m;
      nw = (w_m[p][cls] >= 255) ? 255 : w_m[p][cls] + 1;
      if (nw == 255) sat_m = 1;
      bw = bw_m[p];
      if (DECAY_CYC != 0) begin
        if (br_m[p] != cls && bw > 0) bw = bw - 1;
        for (int j = 0; j < NC; j++)
          if (j != cls && w_m[p][j] > 0) w_m[p][j] = w_m[p][j] - 1;
      end
      w_m[p][cls] = nw;
      if (br_m[p] == cls || nw > bw) begin br_m[p] = cls; bw_m[p] = nw; end
      else bw_m[p] = bw;
    end
    prev_m = cls;
    pv_m = !clr_busy;
    exp_q.push_back(cyc + lat);
    start = 1'b1; class_id = CW'(cls); chain_clear = clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chain_clear = (n == 1) ? clr_busy : 1'b0;
    end while (!done && n < 64);
    if (!done) check_eq("done_timeout", 0, 1);
    chain_clear = 1'b0;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic recall_is(input string tag, input int k, input int resp, input int wt);
    @(negedge clk);
    recall_class = CW'(k);
    @(negedge clk);
    check_eq({tag, "_resp"}, int'(recall_resp), resp);
    check_eq({tag, "_weight"}, int'(recall_weight), wt);
    check_eq({tag, "_valid"}, int'(recall_valid), (wt != 0) ? 1 : 0);
  endtask

  task automatic recall_all(input string tag);
    for (int k = 0; k < NC; k++) recall_is(tag, k, br_m[k], bw_m[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_sat", int'(sat), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_rvalid", int'(recall_valid), 0);
    check_eq("rst_rweight", int'(recall_weight), 0);
    reset = 1'b0;

    // First element, then a single edge.
    learn(3, 0, 0, 0);
    recall_is("t1", 3, 0, 0);
    learn(5, 0, 0, 0);
    recall_is("t2", 3, 5, 1);

    // Competing responses with a tie.
    do_reset();
    repeat (2) begin learn(3, 1, 0, 0); learn(5, 0, 0, 0); end
    learn(3, 1, 0, 0); learn(7, 0, 0, 0);
    learn(3, 1, 0, 0); learn(7, 0, 0, 0);
`ifndef ASSOC_DECAY_EN
    recall_is("t3_tie", 3, 5, 2);
`endif
    recall_is("t3_tie_m", 3, br_m[3], bw_m[3]);
    learn(3, 1, 0, 0); learn(7, 0, 0, 0);
`ifndef ASSOC_DECAY_EN
    recall_is("t3", 3, 7, 3);
`endif
    recall_all("t3_all");

    // Saturation.
    do_reset();
    repeat (254) begin learn(3, 1, 0, 0); learn(5, 0, 0, 0); end
    check_eq("t4_sat_254", int'(sat), 0);
    recall_is("t4_254", 3, 5, 254);
    learn(3, 1, 0, 0); learn(5, 0, 0, 0);
    check_eq("t4_sat_255", int'(sat), 1);
    recall_is("t4_255", 3, 5, 255);
    learn(3, 1, 0, 0); learn(5, 0, 0, 0);
    check_eq("t4_sat_model", int'(sat), int'(sat_m));
    recall_is("t4_nowrap", 3, 5, 255);

    // Stuck start, clear while busy, self edge.
    learn(3, 1, 0, 10);
    learn(5, 0, 1, 0);
    learn(6, 0, 0, 0);
    learn(6, 0, 0, 0);
    recall_is("t5_self", 6, 6, 1);
    recall_all("t5_all");

`ifdef ASSOC_DECAY_EN
    do_reset();
    repeat (2) begin learn(3, 1, 0, 0); learn(7, 0, 0, 0); end
    learn(3, 1, 0, 0); learn(5, 0, 0, 0);
    recall_is("t6_decay", 3, 7, 1);
    recall_all("t6_all");
`endif

    // Reset in the middle of an edge update.
    learn(3, 1, 0, 0);
    @(negedge clk);
    while (busy) @(negedge clk);
    start = 1'b1; class_id = CW'(5);
    repeat (MID_WAIT) @(negedge clk);
    check_eq("mid_busy", int'(busy), 1);
    reset = 1'b1; start = 1'b0;
    #1;
    check_eq("mid_busy_rst", int'(busy), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_sat", int'(sat), 0);
    recall_all("mid_all");
    check_eq("final_err", int'(err), 0);
    repeat (3) @(negedge clk);
    check_eq("final_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
